reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 79 +++++++
 tb/tb_reg_file_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two clocked write ports,
// r0 hardwired to zero, per-register busy scoreboard. Optional bypass: REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic [ADDR_W-1:0] write_reg_a,
    input  logic [DATA_W-1:0] write_data_a,
    input  logic              reg_write_a,
    input  logic [ADDR_W-1:0] write_reg_b,
    input  logic [DATA_W-1:0] write_data_b,
    input  logic              reg_write_b,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_reg
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;

    // Returns {busy, data} for one read port; reset and r0 force zero
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0] res;
        res = {busy_r[addr], regs_r[addr]};
`ifdef REGFILE_BYPASS_EN
        // A matching write forwards its data; busy drops unless a new producer is issued
        res = (reg_write_b && (write_reg_b == addr))
            ? {(busy_set && (busy_reg == addr) && busy_r[addr]), write_data_b}
            : (reg_write_a && (write_reg_a == addr))
            ? {(busy_set && (busy_reg == addr) && busy_r[addr]), write_data_a}
            : res;
`endif
        res = (reset || (addr == {ADDR_W{1'b0}})) ? {(DATA_W+1){1'b0}} : res;
        return res;
    endfunction

    assign {read_busy1, read_data1} = read_port(read_reg1);
    assign {read_busy2, read_data2} = read_port(read_reg2);

    // Next busy state: write-back clears, a new set overrides the clear, r0 never busy
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < DEPTH; r++) begin
            busy_next_s[r] = (busy_set && (busy_reg == ADDR_W'(r)) && (r != 0))
                           | (busy_r[r]
                              & ~((reg_write_a && (write_reg_a == ADDR_W'(r)))
                                | (reg_write_b && (write_reg_b == ADDR_W'(r)))));
        end
    end

    // Register storage and scoreboard; port B written last so it wins conflicts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (reg_write_a && (write_reg_a != {ADDR_W{1'b0}})) begin
                regs_r[write_reg_a] <= write_data_a;
            end
            if (reg_write_b && (write_reg_b != {ADDR_W{1'b0}})) begin
                regs_r[write_reg_b] <= write_data_b;
            end
            busy_r <= busy_next_s;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file_mp;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg_a, write_reg_b, busy_reg;
    logic [31:0] read_data1, read_data2, write_data_a, write_data_b;
    logic        read_busy1, read_busy2, reg_write_a, reg_write_b, busy_set;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] model_regs [32];
    logic        model_busy [32];

    reg_file_mp #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .read_busy1(read_busy1), .read_busy2(read_busy2),
        .write_reg_a(write_reg_a), .write_data_a(write_data_a), .reg_write_a(reg_write_a),
        .write_reg_b(write_reg_b), .write_data_b(write_data_b), .reg_write_b(reg_write_b),
        .busy_set(busy_set), .busy_reg(busy_reg)
    );

    always #5 clock = ~clock;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            model_regs[i] = 32'd0;
            model_busy[i] = 1'b0;
        end
    endfunction

    // Apply one clock edge of architectural behaviour to the model
    function automatic void model_step();
        if (reset) return;
        if (reg_write_a) begin model_regs[write_reg_a] = write_data_a; model_busy[write_reg_a] = 1'b0; end
        if (reg_write_b) begin model_regs[write_reg_b] = write_data_b; model_busy[write_reg_b] = 1'b0; end
        if (busy_set) model_busy[busy_reg] = 1'b1;
        model_regs[0] = 32'd0;
        model_busy[0] = 1'b0;
    endfunction

    // Expected combinational read before the edge with the current write inputs
    function automatic logic [31:0] exp_data(input logic [4:0] addr);
        if (reset || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write_b && write_reg_b == addr) return write_data_b;
        if (reg_write_a && write_reg_a == addr) return write_data_a;
`endif
        return model_regs[addr];
    endfunction

    function automatic logic exp_busy(input logic [4:0] addr);
        if (reset || addr == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((reg_write_a && write_reg_a == addr) || (reg_write_b && write_reg_b == addr))
            && !(busy_set && busy_reg == addr)) return 1'b0;
`endif
        return model_busy[addr];
    endfunction

    task automatic idle_inputs();
        reg_write_a = 1'b0; reg_write_b = 1'b0; busy_set = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        #2;
        read_reg1 = 5'd5; read_reg2 = 5'd6; #1;
        total_cnt++; if (read_data1 !== 32'd0) $display("FAIL reset_init_data got %h exp 0", read_data1); else pass_cnt++;
        total_cnt++; if (read_busy2 !== 1'b0) $display("FAIL reset_init_busy got %b exp 0", read_busy2); else pass_cnt++;
        @(negedge clock); reset = 1'b0;
        write_reg_a = 5'd5; write_data_a = 32'hDEADBEEF; reg_write_a = 1'b1;
        busy_set = 1'b1; busy_reg = 5'd6;
        tick();
        total_cnt++; if (read_data1 !== 32'hDEADBEEF) $display("FAIL pre_reset_write got %h exp deadbeef", read_data1); else pass_cnt++;
        total_cnt++; if (read_busy2 !== 1'b1) $display("FAIL pre_reset_busy got %b exp 1", read_busy2); else pass_cnt++;
        @(posedge clock); #3;
        reset = 1'b1; model_clear(); #1;
        total_cnt++; if (read_data1 !== 32'd0) $display("FAIL async_reset_data got %h exp 0", read_data1); else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            read_reg2 = 5'(i); #1;
            total_cnt++; if (read_busy2 !== 1'b0) $display("FAIL reset_busy r%0d got %b exp 0", i, read_busy2); else pass_cnt++;
        end
        // Writes and busy_set presented while reset is held must be dropped
        write_reg_a = 5'd5; write_data_a = 32'h00001234; reg_write_a = 1'b1;
        busy_set = 1'b1; busy_reg = 5'd5;
        tick();
        @(negedge clock); reset = 1'b0; read_reg1 = 5'd5; #1;
        total_cnt++; if (read_data1 !== 32'd0) $display("FAIL reset_drop_write got %h exp 0", read_data1); else pass_cnt++;
        total_cnt++; if (read_busy1 !== 1'b0) $display("FAIL reset_drop_busy got %b exp 0", read_busy1); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            write_reg_a = 5'(i); write_data_a = i; reg_write_a = 1'b1;
            tick();
        end
        for (int i = 0; i < 31; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i + 1); #1;
            total_cnt++; if (read_data1 !== ((i == 0) ? 32'd0 : 32'(i))) $display("FAIL fill_rd1 r%0d got %h exp %h", i, read_data1, i); else pass_cnt++;
            total_cnt++; if (read_data2 !== 32'(i + 1)) $display("FAIL fill_rd2 r%0d got %h exp %h", i + 1, read_data2, i + 1); else pass_cnt++;
        end
    endtask

    task automatic test_conflict();
        write_reg_a = 5'd7; write_data_a = 32'h11; reg_write_a = 1'b1;
        write_reg_b = 5'd7; write_data_b = 32'h22; reg_write_b = 1'b1;
        tick();
        read_reg1 = 5'd7; #1;
        total_cnt++; if (read_data1 !== 32'h22) $display("FAIL conflict_b_wins got %h exp 22", read_data1); else pass_cnt++;
        write_reg_a = 5'd8; write_data_a = 32'h33; reg_write_a = 1'b1;
        write_reg_b = 5'd9; write_data_b = 32'h44; reg_write_b = 1'b1;
        tick();
        read_reg1 = 5'd8; read_reg2 = 5'd9; #1;
        total_cnt++; if (read_data1 !== 32'h33) $display("FAIL dual_write_a got %h exp 33", read_data1); else pass_cnt++;
        total_cnt++; if (read_data2 !== 32'h44) $display("FAIL dual_write_b got %h exp 44", read_data2); else pass_cnt++;
    endtask

    task automatic test_reg0();
        write_reg_a = 5'd0; write_data_a = 32'hFFFFFFFF; reg_write_a = 1'b1;
        write_reg_b = 5'd0; write_data_b = 32'hFFFFFFFF; reg_write_b = 1'b1;
        busy_set = 1'b1; busy_reg = 5'd0;
        read_reg1 = 5'd0; read_reg2 = 5'd0; #1;
        total_cnt++; if (read_data1 !== 32'd0) $display("FAIL r0_pre_edge got %h exp 0", read_data1); else pass_cnt++;
        tick();
        total_cnt++; if (read_data2 !== 32'd0) $display("FAIL r0_data got %h exp 0", read_data2); else pass_cnt++;
        total_cnt++; if (read_busy1 !== 1'b0) $display("FAIL r0_busy got %b exp 0", read_busy1); else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        read_reg1 = 5'd3;
        busy_set = 1'b1; busy_reg = 5'd3;
        tick();
        total_cnt++; if (read_busy1 !== 1'b1) $display("FAIL sb_set got %b exp 1", read_busy1); else pass_cnt++;
        write_reg_b = 5'd3; write_data_b = 32'h55; reg_write_b = 1'b1;
        busy_set = 1'b1; busy_reg = 5'd3;
        tick();
        total_cnt++; if (read_busy1 !== 1'b1) $display("FAIL sb_set_beats_clear got %b exp 1", read_busy1); else pass_cnt++;
        write_reg_a = 5'd3; write_data_a = 32'h66; reg_write_a = 1'b1;
        tick();
        total_cnt++; if (read_busy1 !== 1'b0) $display("FAIL sb_clear got %b exp 0", read_busy1); else pass_cnt++;
        total_cnt++; if (read_data1 !== 32'h66) $display("FAIL sb_data got %h exp 66", read_data1); else pass_cnt++;
    endtask

    task automatic test_bypass();
        read_reg1 = 5'd10;
        write_reg_a = 5'd10; write_data_a = 32'h0000CAFE; reg_write_a = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
        total_cnt++; if (read_data1 !== 32'h0000CAFE) $display("FAIL bypass_pre got %h exp cafe", read_data1); else pass_cnt++;
`else
        total_cnt++; if (read_data1 !== 32'd10) $display("FAIL bypass_pre got %h exp 0000000a", read_data1); else pass_cnt++;
`endif
        tick();
        total_cnt++; if (read_data1 !== 32'h0000CAFE) $display("FAIL bypass_post got %h exp cafe", read_data1); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            read_reg1 = 5'($urandom_range(0, 7)); read_reg2 = 5'($urandom_range(0, 7));
            write_reg_a = 5'($urandom_range(0, 7)); write_data_a = $urandom; reg_write_a = 1'($urandom_range(0, 1));
            write_reg_b = 5'($urandom_range(0, 7)); write_data_b = $urandom; reg_write_b = 1'($urandom_range(0, 1));
            busy_reg = 5'($urandom_range(0, 7)); busy_set = 1'($urandom_range(0, 1));
            #1;
            total_cnt++; if (read_data1 !== exp_data(read_reg1)) $display("FAIL rand_pre_rd1 it%0d r%0d got %h exp %h", n, read_reg1, read_data1, exp_data(read_reg1)); else pass_cnt++;
            total_cnt++; if (read_busy2 !== exp_busy(read_reg2)) $display("FAIL rand_pre_busy2 it%0d r%0d got %b exp %b", n, read_reg2, read_busy2, exp_busy(read_reg2)); else pass_cnt++;
            tick();
            total_cnt++; if (read_data2 !== model_regs[read_reg2]) $display("FAIL rand_post_rd2 it%0d r%0d got %h exp %h", n, read_reg2, read_data2, model_regs[read_reg2]); else pass_cnt++;
            total_cnt++; if (read_busy1 !== model_busy[read_reg1]) $display("FAIL rand_post_busy1 it%0d r%0d got %b exp %b", n, read_reg1, read_busy1, model_busy[read_reg1]); else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        read_reg1 = 5'd0; read_reg2 = 5'd0; busy_reg = 5'd0;
        write_reg_a = 5'd0; write_reg_b = 5'd0; write_data_a = 32'd0; write_data_b = 32'd0;
        model_clear();
        test_reset();
        test_fill();
        test_conflict();
        test_reg0();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
